// File: rtl/core_pkg.sv
// Shared core definitions for the writeback path: data width, register index
// width and the writeback request record used by every producer.
package core_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // One writeback producer's offer to the register-file write port.
  typedef struct packed {
    logic            valid;
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the writeback port: starting at the pointer, the
// first valid requester (searching upward, modulo NUM_REQ) gets a one-hot grant.
// The pointer moves to one past the granted index on every transfer.
// Build option WB_ARB_FIXED_PRIO_EN: lowest index always wins and the pointer
// (together with its clock/reset ports) disappears.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
`ifndef WB_ARB_FIXED_PRIO_EN
  input  logic                       clk,
  input  logic                       rst_n,
`endif
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

`ifdef WB_ARB_FIXED_PRIO_EN

  // Fixed priority: scan from the top down so the lowest valid index is the last write.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_idx   = IDX_W'(i);
        grant_valid = 1'b1;
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

`else

  logic [IDX_W-1:0] ptr;

  // Rotated priority search: the first valid index at or after ptr wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  // Pointer advances past the winner only when a transfer actually happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback producers.
// Grants are combinational (rr_arbiter); the accepted write is registered once
// and presented to the register file the following cycle. A pending-write
// scoreboard (busy) is set at issue and cleared when the write commits.
// Build option WB_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module wb_port_arbiter
  import core_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int XLEN     = core_pkg::XLEN,
  parameter int NUM_REGS = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][REG_IDX_W-1:0]   req_rd,
  input  logic [NUM_REQ-1:0][XLEN-1:0]        req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                alloc_valid,
  input  logic [REG_IDX_W-1:0]                alloc_rd,
  input  logic                                flush,
  output logic                                rf_we,
  output logic [REG_IDX_W-1:0]                rf_rd,
  output logic [XLEN-1:0]                     rf_wdata,
  output logic [NUM_REGS-1:0]                 busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  wb_req_t              reqs [NUM_REQ];
  logic [NUM_REQ-1:0]   arb_req;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  busy_next;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign reqs[i]    = {req_valid[i], req_rd[i], req_data[i]};
    assign arb_req[i] = reqs[i].valid;
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
`ifndef WB_ARB_FIXED_PRIO_EN
    .clk         (clk),
    .rst_n       (rst_n),
`endif
    .req         (arb_req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // A grant is only ever issued to a valid requester, so grant doubles as ready.
  assign req_ready = grant;

  // Output stage: capture the winner; rd=0 consumes the slot but never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= grant_valid && (reqs[grant_idx].rd != '0);
      if (grant_valid) begin
        rf_rd    <= reqs[grant_idx].rd;
        rf_wdata <= reqs[grant_idx].data;
      end
    end
  end

  // Scoreboard next state: commit clears, issue sets afterwards so a new producer wins.
  always_comb begin
    busy_next = busy_q;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (rf_we) busy_next[rf_rd] = 1'b0;
      if (alloc_valid && (alloc_rd != '0)) busy_next[alloc_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register; the hazard unit only ever sees the registered copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter. Requesters are modelled as per-port pending
// slots held until granted; the reference model picks the winner from the
// arbitration rules and queues the expected register-file write with its cycle.
// Build option WB_ARB_FIXED_PRIO_EN switches the model to fixed priority.
module tb_wb_port_arbiter;

  localparam int N  = 3;
  localparam int XL = 32;
  localparam int NR = 32;

  typedef struct {
    int          stamp;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N-1:0]          req_valid;
  logic [N-1:0][4:0]     req_rd;
  logic [N-1:0][XL-1:0]  req_data;
  logic [N-1:0]          req_ready;
  logic                  alloc_valid;
  logic [4:0]            alloc_rd;
  logic                  flush;
  logic                  rf_we;
  logic [4:0]            rf_rd;
  logic [XL-1:0]         rf_wdata;
  logic [NR-1:0]         busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state.
  int          ptr_m;
  logic [NR-1:0] busy_m;
  bit          infl_we;
  logic [4:0]  infl_rd;
  bit          pend_v [N];
  logic [4:0]  pend_rd [N];
  logic [31:0] pend_d [N];
  exp_t        q [$];

  wb_port_arbiter #(
    .NUM_REQ  (N),
    .XLEN     (XL),
    .NUM_REGS (NR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .flush       (flush),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_wdata    (rf_wdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Count rising edges so expected writes can be tied to an absolute cycle.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every register-file write must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rf_we === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL writeback: got unexpected write rd=%0d data=%0h at cycle %0d", rf_rd, rf_wdata, cyc);
        end else begin
          e = q.pop_front();
          if (e.stamp != cyc || rf_rd !== e.rd || rf_wdata !== e.data) begin
            n_fail++;
            $display("[TB] FAIL writeback: got rd=%0d data=%0h at cycle %0d, expected rd=%0d data=%0h at cycle %0d",
                     rf_rd, rf_wdata, cyc, e.rd, e.data, e.stamp);
          end
        end
      end else if (rf_we !== 1'b0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL rf_we: got %b expected 0/1", rf_we);
      end else if (q.size() > 0 && q[0].stamp <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL writeback: got no write at cycle %0d, expected rd=%0d data=%0h", cyc, e.rd, e.data);
      end
    end
  end

  // One cycle of stimulus: drive pending requests, check ready/busy, advance model.
  task automatic apply_stimulus(input bit rnd, input bit a_v, input logic [4:0] a_rd, input bit fl);
    int g;
    logic [N-1:0] exp_ready;
    exp_t e;
    @(negedge clk);
    #1;
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
          pend_v[i]  = 1'b1;
          pend_rd[i] = 5'($urandom_range(0, 7));
          pend_d[i]  = $urandom;
        end
      end
      alloc_valid = ($urandom_range(0, 2) == 0);
      alloc_rd    = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 19) == 0);
    end else begin
      alloc_valid = a_v;
      alloc_rd    = a_rd;
      flush       = fl;
    end
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend_v[i];
      req_rd[i]    = pend_rd[i];
      req_data[i]  = pend_d[i];
    end
    #1;
    g = -1;
`ifdef WB_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (g < 0 && pend_v[k]) g = k;
`else
    for (int k = 0; k < N; k++) if (g < 0 && pend_v[(ptr_m + k) % N]) g = (ptr_m + k) % N;
`endif
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check_output("req_ready", req_ready, exp_ready);
    check_output("busy", busy, busy_m);
    if (flush) begin
      busy_m = '0;
    end else begin
      if (infl_we) busy_m[infl_rd] = 1'b0;
      if (alloc_valid && alloc_rd != 0) busy_m[alloc_rd] = 1'b1;
    end
    infl_we = 1'b0;
    if (g >= 0) begin
      if (pend_rd[g] != 0) begin
        e.stamp = cyc + 1;
        e.rd    = pend_rd[g];
        e.data  = pend_d[g];
        q.push_back(e);
        infl_we = 1'b1;
        infl_rd = pend_rd[g];
      end
`ifndef WB_ARB_FIXED_PRIO_EN
      ptr_m = (g + 1) % N;
`endif
      pend_v[g] = 1'b0;
    end
    @(posedge clk);
    #1;
    req_valid   = '0;
    alloc_valid = 1'b0;
    flush       = 1'b0;
  endtask

  // Asynchronous reset in the middle of a cycle while a write is being presented.
  task automatic reset_mid();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("rst_rf_we", rf_we, 0);
    check_output("rst_busy", busy, 0);
    ptr_m   = 0;
    busy_m  = '0;
    infl_we = 1'b0;
    q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    req_valid   = '0;
    req_rd      = '0;
    req_data    = '0;
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    flush       = 1'b0;
    ptr_m       = 0;
    busy_m      = '0;
    infl_we     = 1'b0;
    infl_rd     = '0;
    for (int i = 0; i < N; i++) begin
      pend_v[i]  = 1'b0;
      pend_rd[i] = '0;
      pend_d[i]  = '0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_rf_we", rf_we, 0);
    check_output("reset_rf_rd", rf_rd, 0);
    check_output("reset_rf_wdata", rf_wdata, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_ready", req_ready, 0);
    #1 rst_n = 1'b1;

    // Single request from port 0.
    pend_v[0] = 1'b1; pend_rd[0] = 5'd5; pend_d[0] = 32'hDEADBEEF;
    repeat (3) apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0);

    // All ports continuously requesting.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i]) begin
          pend_v[i] = 1'b1; pend_rd[i] = 5'(i + 1); pend_d[i] = $urandom;
        end
      end
      apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0);
    end
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;

    // rd=0 request consumes a slot without writing.
    pend_v[1] = 1'b1; pend_rd[1] = 5'd0; pend_d[1] = 32'h1234_5678;
    repeat (2) apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0);

    // Allocate rd=7, write it back later, then watch busy clear.
    apply_stimulus(1'b0, 1'b1, 5'd7, 1'b0);
    apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0);
    pend_v[2] = 1'b1; pend_rd[2] = 5'd7; pend_d[2] = 32'hA5A5_0007;
    repeat (3) apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0);

    // Clear and re-allocate rd=9 on the same edge; alloc of rd=0 is ignored.
    pend_v[0] = 1'b1; pend_rd[0] = 5'd9; pend_d[0] = 32'h0000_0099;
    apply_stimulus(1'b0, 1'b1, 5'd9, 1'b0);
    apply_stimulus(1'b0, 1'b1, 5'd9, 1'b0);
    apply_stimulus(1'b0, 1'b1, 5'd0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0);

    // Flush with a write granted on the flush edge: busy clears, write still lands.
    apply_stimulus(1'b0, 1'b1, 5'd4, 1'b0);
    apply_stimulus(1'b0, 1'b1, 5'd8, 1'b0);
    pend_v[1] = 1'b1; pend_rd[1] = 5'd3; pend_d[1] = 32'hF1F1_0003;
    apply_stimulus(1'b0, 1'b1, 5'd6, 1'b1);
    repeat (2) apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0);

    // Reset while a write is on the register-file port.
    pend_v[2] = 1'b1; pend_rd[2] = 5'd10; pend_d[2] = 32'hCAFE_000A;
    apply_stimulus(1'b0, 1'b1, 5'd10, 1'b0);
    reset_mid();
    apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0);

    // Randomised traffic, then drain.
    repeat (400) apply_stimulus(1'b1, 1'b0, 5'd0, 1'b0);
    repeat (8) apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_output("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
